// File: rtl/data_ram_ctrl.sv
// Multi-cycle data RAM responder on the core's valid/busy load-store port.
// Define DRAM_RANGE_CHECK_EN to flag and suppress accesses beyond the depth.
module data_ram_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [3:0]  byte_en,
    input  logic [31:0] store_data,
    output logic [31:0] data_o,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 2);

    state_t state, state_n;
    logic [3:0] cnt, cnt_n;

    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [3:0]            be_q;
    logic [31:0]           sd_q;
    logic                  oor_q;

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    logic                  accept, finish;
    logic                  c_wr, c_oor;
    logic [ADDR_WIDTH-1:0] c_idx;
    logic [3:0]            c_be;
    logic [31:0]           c_sd;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  oor;
    logic                  unused_addr;

    assign idx = addr[ADDR_WIDTH+1:2];

`ifdef DRAM_RANGE_CHECK_EN
    assign oor         = |addr[31:ADDR_WIDTH+2];
    assign unused_addr = ^addr[1:0];
`else
    assign oor         = 1'b0;
    assign unused_addr = ^{addr[1:0], addr[31:ADDR_WIDTH+2]};
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        finish  = 1'b0;
        busy    = 1'b0;
        case (state)
            IDLE: begin
                if (valid && rst) begin
                    busy   = 1'b1;
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_n = DONE;
                        finish  = 1'b1;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt == 4'd0) begin
                    state_n = DONE;
                    finish  = 1'b1;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Single-cycle latency commits straight from the live request.
    always_comb begin
        if (state == IDLE) begin
            c_wr  = write;
            c_idx = idx;
            c_be  = byte_en;
            c_sd  = store_data;
            c_oor = oor;
        end else begin
            c_wr  = wr_q;
            c_idx = idx_q;
            c_be  = be_q;
            c_sd  = sd_q;
            c_oor = oor_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            wr_q   <= 1'b0;
            idx_q  <= '0;
            be_q   <= 4'd0;
            sd_q   <= 32'h0;
            oor_q  <= 1'b0;
            data_o <= 32'h0;
            err    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            err   <= finish && c_oor;
            if (accept) begin
                wr_q  <= write;
                idx_q <= idx;
                be_q  <= byte_en;
                sd_q  <= store_data;
                oor_q <= oor;
            end
            if (finish && !c_wr)
                data_o <= c_oor ? 32'h0 : mem[c_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (finish && c_wr && !c_oor) begin
            for (int i = 0; i < 4; i++)
                if (c_be[i])
                    mem[c_idx][8*i +: 8] <= c_sd[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl: LATENCY=3 and LATENCY=1 instances.
// Expectations follow DRAM_RANGE_CHECK_EN when it is defined.
module tb_data_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        sel;
    logic        write;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] sd;

    logic        valid3, valid1;
    logic [31:0] data3, data1;
    logic        busy3, busy1, err3, err1;
    logic        busy_s, err_s;
    logic [31:0] data_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign valid3 = valid & ~sel;
    assign valid1 = valid & sel;
    assign busy_s = sel ? busy1 : busy3;
    assign err_s  = sel ? err1  : err3;
    assign data_s = sel ? data1 : data3;

    data_ram_ctrl #(.ADDR_WIDTH(10), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .valid(valid3), .write(write),
        .addr(addr), .byte_en(be), .store_data(sd),
        .data_o(data3), .busy(busy3), .err(err3)
    );

    data_ram_ctrl #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .valid(valid1), .write(write),
        .addr(addr), .byte_en(be), .store_data(sd),
        .data_o(data1), .busy(busy1), .err(err1)
    );

`ifdef DRAM_RANGE_CHECK_EN
    localparam logic        OOR_ERR  = 1'b1;
    localparam logic [31:0] OOR_LOAD = 32'h0;
    localparam logic [31:0] W0_AFTER = 32'h0BADF00D;
`else
    localparam logic        OOR_ERR  = 1'b0;
    localparam logic [31:0] OOR_LOAD = 32'h77777777;
    localparam logic [31:0] W0_AFTER = 32'h77777777;
`endif

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  b;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic access(input logic s, input logic w,
                          input logic [31:0] a, input logic [3:0] b,
                          input logic [31:0] d, output int nb,
                          output logic [31:0] q, output logic e);
        @(negedge clk);
        sel   = s;
        write = w;
        addr  = a;
        be    = b;
        sd    = d;
        valid = 1'b1;
        #1;
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy_s) break;
            nb++;
            @(negedge clk);
        end
        q     = data_s;
        e     = err_s;
        valid = 1'b0;
    endtask

    initial begin
        int          nb;
        logic [31:0] q;
        logic        e;

        vt[0]  = '{1'b1, 32'h40,  4'hF, 32'hDEADBEEF, 32'h0};
        vt[1]  = '{1'b0, 32'h40,  4'h0, 32'h0,        32'hDEADBEEF};
        vt[2]  = '{1'b1, 32'h80,  4'hF, 32'h11223344, 32'hDEADBEEF};
        vt[3]  = '{1'b1, 32'h80,  4'h5, 32'hAABBCCDD, 32'hDEADBEEF};
        vt[4]  = '{1'b0, 32'h80,  4'h0, 32'h0,        32'h11BB33DD};
        vt[5]  = '{1'b1, 32'h40,  4'h0, 32'h0,        32'h11BB33DD};
        vt[6]  = '{1'b0, 32'h43,  4'h0, 32'h0,        32'hDEADBEEF};
        vt[7]  = '{1'b1, 32'h44,  4'hF, 32'h12345678, 32'hDEADBEEF};
        vt[8]  = '{1'b1, 32'h44,  4'h8, 32'h9ABCDEF0, 32'hDEADBEEF};
        vt[9]  = '{1'b0, 32'h44,  4'h0, 32'h0,        32'h9A345678};
        vt[10] = '{1'b1, 32'h100, 4'hF, 32'h55AA55AA, 32'h9A345678};
        vt[11] = '{1'b0, 32'h100, 4'h0, 32'h0,        32'h55AA55AA};

        rst   = 1'b0;
        valid = 1'b0;
        sel   = 1'b0;
        write = 1'b0;
        addr  = 32'h0;
        be    = 4'h0;
        sd    = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy3", {31'b0, busy3}, 32'h0);
        chk("rst_data3", data3, 32'h0);
        chk("rst_err3", {31'b0, err3}, 32'h0);
        chk("rst_busy1", {31'b0, busy1}, 32'h0);
        chk("rst_data1", data1, 32'h0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_busy3", {31'b0, busy3}, 32'h0);
        chk("idle_busy1", {31'b0, busy1}, 32'h0);

        for (int i = 0; i < 12; i++) begin
            access(1'b0, vt[i].w, vt[i].a, vt[i].b, vt[i].d, nb, q, e);
            chk($sformatf("lat3_busy[%0d]", i), nb, 32'd3);
            chk($sformatf("lat3_data[%0d]", i), q, vt[i].exp);
            chk($sformatf("lat3_err[%0d]", i), {31'b0, e}, 32'h0);
        end

        access(1'b0, 1'b1, 32'h0, 4'hF, 32'h0BADF00D, nb, q, e);
        chk("w0_err", {31'b0, e}, 32'h0);
        access(1'b0, 1'b1, 32'h1000, 4'hF, 32'h77777777, nb, q, e);
        chk("oor_st_err", {31'b0, e}, {31'b0, OOR_ERR});
        chk("oor_st_busy", nb, 32'd3);
        access(1'b0, 1'b0, 32'h1000, 4'h0, 32'h0, nb, q, e);
        chk("oor_ld_err", {31'b0, e}, {31'b0, OOR_ERR});
        chk("oor_ld_data", q, OOR_LOAD);
        chk("oor_ld_busy", nb, 32'd3);
        @(negedge clk);
        chk("oor_err_gone", {31'b0, err3}, 32'h0);
        access(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, nb, q, e);
        chk("w0_data", q, W0_AFTER);
        chk("w0_ld_err", {31'b0, e}, 32'h0);

        // valid dropped after acceptance: access still completes
        @(negedge clk);
        sel   = 1'b0;
        write = 1'b0;
        addr  = 32'h80;
        valid = 1'b1;
        #1;
        chk("vdrop_c0", {31'b0, busy3}, 32'h1);
        @(negedge clk);
        valid = 1'b0;
        addr  = 32'h40;
        write = 1'b1;
        #1;
        chk("vdrop_c1", {31'b0, busy3}, 32'h1);
        @(negedge clk);
        chk("vdrop_c2", {31'b0, busy3}, 32'h1);
        @(negedge clk);
        chk("vdrop_c3", {31'b0, busy3}, 32'h0);
        chk("vdrop_data", data3, 32'h11BB33DD);

        // reset in the second WAIT cycle drops the store
        access(1'b0, 1'b1, 32'h200, 4'hF, 32'h0, nb, q, e);
        access(1'b0, 1'b0, 32'h40, 4'h0, 32'h0, nb, q, e);
        chk("pre_rst_data", q, 32'hDEADBEEF);
        @(negedge clk);
        write = 1'b1;
        addr  = 32'h200;
        be    = 4'hF;
        sd    = 32'hFFFFFFFF;
        valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst   = 1'b0;
        valid = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy3}, 32'h0);
        chk("midrst_data", data3, 32'h0);
        #2;
        rst = 1'b1;
        access(1'b0, 1'b0, 32'h200, 4'h0, 32'h0, nb, q, e);
        chk("midrst_word", q, 32'h0);
        chk("midrst_busy_ld", nb, 32'd3);

        // LATENCY=1 instance
        access(1'b1, 1'b1, 32'h0, 4'hF, 32'h01020304, nb, q, e);
        chk("l1_st0_busy", nb, 32'd1);
        access(1'b1, 1'b1, 32'h4, 4'hF, 32'hA0B0C0D0, nb, q, e);
        chk("l1_st4_busy", nb, 32'd1);
        @(negedge clk);
        sel   = 1'b1;
        write = 1'b0;
        addr  = 32'h0;
        valid = 1'b1;
        #1;
        chk("l1_c0_busy", {31'b0, busy1}, 32'h1);
        @(negedge clk);
        chk("l1_c1_busy", {31'b0, busy1}, 32'h0);
        chk("l1_c1_data", data1, 32'h01020304);
        addr = 32'h4;
        #1;
        chk("l1_done_noacc", {31'b0, busy1}, 32'h0);
        @(negedge clk);
        chk("l1_c2_busy", {31'b0, busy1}, 32'h1);
        @(negedge clk);
        valid = 1'b0;
        chk("l1_c3_busy", {31'b0, busy1}, 32'h0);
        chk("l1_c3_data", data1, 32'hA0B0C0D0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
